// File: rtl/drum_dot_accum.sv
// Dot-product accumulator behind the DRUM approximate multiplier: sums VEC_LEN
// unsigned products per result with saturation and a sticky overflow flag.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  ACCUM | accepting products, acc_q holds the running sum
//  HOLD  | vector complete, result presented until the sink takes it
module drum_dot_accum #(
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 24,
  parameter int VEC_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_ovf
);

  localparam logic [7:0]       LAST_IDX = 8'(VEC_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = '1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   sum;

  // One extra bit so the carry out of the add flags saturation.
  assign sum = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (prod_valid) begin
            acc_d   = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
            ovf_d   = ovf_q | sum[ACC_W];
            count_d = count_q + 8'd1;
            if (count_q == LAST_IDX) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  assign prod_ready = (state_q == ACCUM);
  assign acc_valid  = (state_q == HOLD);
  assign acc_out    = acc_q;
  assign acc_ovf    = ovf_q;

endmodule

// File: tb/tb_drum_dot_accum.sv
// Directed and randomized checks of drum_dot_accum against a sum-and-saturate
// model, with a second instance configured narrow to reach saturation.
module tb_drum_dot_accum;

  logic        clk;
  logic        rst_n;

  logic        clear, pv, pr, av, ar, ov;
  logic [15:0] prod;
  logic [23:0] ao;

  logic        s_clear, s_pv, s_pr, s_av, s_ar, s_ov;
  logic [15:0] s_prod;
  logic [16:0] s_ao;

  int checks   = 0;
  int failures = 0;

  logic [15:0] vq[$];

  drum_dot_accum #(.PROD_W(16), .ACC_W(24), .VEC_LEN(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .prod_valid(pv), .prod_ready(pr), .prod(prod),
    .acc_valid(av), .acc_ready(ar), .acc_out(ao), .acc_ovf(ov)
  );

  drum_dot_accum #(.PROD_W(16), .ACC_W(17), .VEC_LEN(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(s_clear),
    .prod_valid(s_pv), .prod_ready(s_pr), .prod(s_prod),
    .acc_valid(s_av), .acc_ready(s_ar), .acc_out(s_ao), .acc_ovf(s_ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the exact sum of the vector, clipped at the accumulator maximum.
  // All terms are non-negative, so clipping the final sum equals clipping each step.
  function automatic void model(input int accw, output longint val, output bit ovf);
    longint s   = 0;
    longint lim = (longint'(1) << accw) - 1;
    foreach (vq[i]) s += longint'(vq[i]);
    ovf = (s > lim);
    val = ovf ? lim : s;
  endfunction

  // DRUM with a 4-bit core: keep the leading 4 bits, force the lowest kept bit to 1.
  function automatic int drum_op(input int v, output int sh);
    int msb = 0;
    for (int b = 0; b < 8; b++) if (v[b]) msb = b;
    if (msb < 4) begin
      sh = 0;
      return v;
    end
    sh = msb - 3;
    return (v >> sh) | 1;
  endfunction

  function automatic logic [15:0] drum_mul(input logic [7:0] a, input logic [7:0] b);
    int sa, sb, ta, tb;
    ta = drum_op(int'(a), sa);
    tb = drum_op(int'(b), sb);
    return 16'((ta * tb) << (sa + sb));
  endfunction

  task automatic send_main(input logic [15:0] p, input int max_gap);
    int n = 0;
    repeat ($urandom_range(0, max_gap)) tick();
    pv   = 1'b1;
    prod = p;
    while (pr !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("main_ready_timeout", {31'b0, pr}, 32'd1);
    tick();
    pv = 1'b0;
  endtask

  task automatic send_sat(input logic [15:0] p, input int max_gap);
    int n = 0;
    repeat ($urandom_range(0, max_gap)) tick();
    s_pv   = 1'b1;
    s_prod = p;
    while (s_pr !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("sat_ready_timeout", {31'b0, s_pr}, 32'd1);
    tick();
    s_pv = 1'b0;
  endtask

  // Sends vq, checks the result one cycle after the last transfer, holds it
  // under backpressure with junk on the product port, then acknowledges.
  task automatic main_run(input string tag, input int max_gap, input int hold_cycles);
    longint e;
    bit     eo;
    model(24, e, eo);
    foreach (vq[i]) send_main(vq[i], max_gap);
    check({tag, "_valid"}, {31'b0, av}, 32'd1);
    check({tag, "_sum"}, {8'b0, ao}, {8'b0, e[23:0]});
    check({tag, "_ovf"}, {31'b0, ov}, {31'b0, eo});
    pv   = 1'b1;
    prod = 16'hFFFF;
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      check({tag, "_hold_sum"}, {8'b0, ao}, {8'b0, e[23:0]});
      check({tag, "_hold_ready"}, {31'b0, pr}, 32'd0);
    end
    pv = 1'b0;
    ar = 1'b1;
    tick();
    ar = 1'b0;
    check({tag, "_ack_valid"}, {31'b0, av}, 32'd0);
    check({tag, "_ack_ready"}, {31'b0, pr}, 32'd1);
  endtask

  task automatic sat_run(input string tag, input int max_gap, input int hold_cycles);
    longint e;
    bit     eo;
    model(17, e, eo);
    foreach (vq[i]) send_sat(vq[i], max_gap);
    check({tag, "_valid"}, {31'b0, s_av}, 32'd1);
    check({tag, "_sum"}, {15'b0, s_ao}, {15'b0, e[16:0]});
    check({tag, "_ovf"}, {31'b0, s_ov}, {31'b0, eo});
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      check({tag, "_hold_ovf"}, {31'b0, s_ov}, {31'b0, eo});
    end
    s_ar = 1'b1;
    tick();
    s_ar = 1'b0;
    check({tag, "_ack_valid"}, {31'b0, s_av}, 32'd0);
    check({tag, "_ack_ovf"}, {31'b0, s_ov}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear = 1'b0; pv = 1'b0; prod = '0; ar = 1'b0;
    s_clear = 1'b0; s_pv = 1'b0; s_prod = '0; s_ar = 1'b0;
    #12;
    check("rst_valid", {31'b0, av}, 32'd0);
    check("rst_sum", {8'b0, ao}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_release_ready", {31'b0, pr}, 32'd1);

    // Asynchronous reset mid-vector and again while a result is pending.
    for (int i = 0; i < 3; i++) send_main(16'h1000, 0);
    check("pre_rst_sum", {8'b0, ao}, 32'h3000);
    rst_n = 1'b0;
    #2;
    check("async_rst_sum", {8'b0, ao}, 32'd0);
    check("async_rst_valid", {31'b0, av}, 32'd0);
    check("async_rst_ovf", {31'b0, ov}, 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send_main(16'h0001, 0);
    check("pre_rst2_valid", {31'b0, av}, 32'd1);
    rst_n = 1'b0;
    #2;
    check("async_rst2_valid", {31'b0, av}, 32'd0);
    check("async_rst2_sum", {8'b0, ao}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("rst2_release_ready", {31'b0, pr}, 32'd1);

    // Basic vector with no gaps; the seventh transfer must not raise valid.
    vq.delete();
    for (int i = 0; i < 7; i++) send_main(16'h1000, 0);
    check("basic_early_valid", {31'b0, av}, 32'd0);
    send_main(16'h1000, 0);
    check("basic_valid", {31'b0, av}, 32'd1);
    check("basic_sum", {8'b0, ao}, 32'h008000);
    check("basic_ovf", {31'b0, ov}, 32'd0);
    ar = 1'b1;
    tick();
    ar = 1'b0;
    check("basic_ack_valid", {31'b0, av}, 32'd0);

    // Gaps and 10 cycles of backpressure, then a vector of ones.
    vq.delete();
    for (int i = 1; i <= 8; i++) vq.push_back(16'(i));
    main_run("gaps", 3, 10);
    vq.delete();
    for (int i = 0; i < 8; i++) vq.push_back(16'h0001);
    main_run("after_bp", 1, 0);

    // Saturation on the narrow instance, then a clean vector.
    vq.delete();
    for (int i = 0; i < 4; i++) vq.push_back(16'hFFFF);
    sat_run("sat", 0, 2);
    vq.delete();
    for (int i = 0; i < 4; i++) vq.push_back(16'h0001);
    sat_run("sat_next", 0, 0);

    // Clear together with a valid 4th product drops it and restarts the count.
    for (int i = 0; i < 3; i++) send_main(16'h0005, 0);
    clear = 1'b1; pv = 1'b1; prod = 16'h0007;
    tick();
    clear = 1'b0; pv = 1'b0;
    check("clr_sum", {8'b0, ao}, 32'd0);
    check("clr_valid", {31'b0, av}, 32'd0);
    vq.delete();
    for (int i = 0; i < 8; i++) vq.push_back(16'h0002);
    main_run("clr_next", 1, 0);

    // Clear while holding a result discards it.
    for (int i = 0; i < 8; i++) send_main(16'h0003, 0);
    check("clr_hold_pre_valid", {31'b0, av}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_hold_valid", {31'b0, av}, 32'd0);
    check("clr_hold_sum", {8'b0, ao}, 32'd0);
    check("clr_hold_ready", {31'b0, pr}, 32'd1);
    vq.delete();
    for (int i = 0; i < 8; i++) vq.push_back(16'h0001);
    main_run("clr_hold_next", 0, 0);

    // Products from the DRUM multiplier model.
    vq.delete();
    for (int i = 0; i < 8; i++) vq.push_back(drum_mul(8'b01100010, 8'b10100010));
    main_run("drum", 1, 2);

    // Randomized vectors on both instances.
    for (int v = 0; v < 12; v++) begin
      vq.delete();
      for (int i = 0; i < 8; i++) vq.push_back(16'($urandom_range(0, 16'hFFFF)));
      main_run("rand_main", 2, int'($urandom_range(0, 3)));
    end
    for (int v = 0; v < 10; v++) begin
      vq.delete();
      for (int i = 0; i < 4; i++)
        vq.push_back($urandom_range(0, 1) ? 16'($urandom_range(0, 16'hFFFF))
                                          : 16'($urandom_range(0, 16'h3FFF)));
      sat_run("rand_sat", 2, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
